mmc3_scanline_irq: RTL and testbench
====================================

Name: mmc3_scanline_irq

Overview:
- MMC3-style scanline IRQ generator for the multicart mapper logic.
- Sits directly upstream of the top-level `irq` pin. It consumes CPU register writes already decoded from the $8000-$FFFF window and the PPU A12 line, and produces the active-low IRQ request that the top level drives as open-drain.
- Used by mappers #004/#118/#189 and any MMC3-derivative selected in the mapper set.

Parameters:
- A12_LOW_MIN, 3, minimum consecutive m2 cycles A12 must be sampled low before a rising edge counts as a scanline clock.
- CNT_WIDTH, 8, width of the latch and down-counter.

Ports:
- m2  input  1  CPU M2 clock; all state updates on its rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising m2.
- enable  input  1  block selected by the current mapper; 0 freezes the counter and forces irq_n high.
- wr_strobe  input  1  one-cycle pulse: a CPU write to $8000-$FFFF has completed.
- wr_a14_13  input  2  CPU A14:A13 of that write.
- wr_a0  input  1  CPU A0 of that write.
- wr_data  input  CNT_WIDTH  CPU data of that write.
- ppu_a12  input  1  raw PPU address bit 12, asynchronous to m2.
- irq_n  output  1  IRQ request, 0 = asserted.
- irq_pending  output  1  internal pending flag, for status readback.
- counter_q  output  CNT_WIDTH  current counter value, for debug and verification.

Behaviour:
- Reset (reset_n=0 at rising m2):
  - latch=0, counter=0, reload=0, irq_en=0, pending=0.
  - A12 synchroniser and low-count cleared.
  - irq_n=1, irq_pending=0, counter_q=0.
- A12 path:
  - 2-flop synchroniser on ppu_a12.
  - low_cnt saturating counter, ceiling A12_LOW_MIN. It increments while the synced A12 is 0 and clears when it is 1.
  - a12_clk pulses for exactly one cycle when the synced A12 goes 0→1 and low_cnt == A12_LOW_MIN.
  - A rise after a shorter low period is ignored; this filters the sprite-fetch chatter.
  - Latency from raw edge to a12_clk: 2-3 m2 cycles.
- Register writes, applied when wr_strobe=1 and enable=1:
  - A14:A13=2, A0=0 ($C000): latch ← wr_data.
  - A14:A13=2, A0=1 ($C001): counter ← 0, reload ← 1.
  - A14:A13=3, A0=0 ($E000): irq_en ← 0, pending ← 0 (acknowledge).
  - A14:A13=3, A0=1 ($E001): irq_en ← 1.
  - A14:A13 = 0 or 1: ignored.
- Counter, on each a12_clk with enable=1:
  - If counter==0 or reload=1: counter ← latch, reload ← 0. Otherwise counter ← counter-1.
  - new = value just written.
  - If new==0 and irq_en=1: pending ← 1.
- Simultaneous events in one cycle:
  - $C001 write with a12_clk: the write wins. counter=0, reload=1, no decrement. The a12_clk is consumed and pending is not set.
  - $E000 write with a pending-setting a12_clk: the clear wins, pending=0.
  - $C000 write with a reload a12_clk: the reload uses the old latch; the new latch applies from the next cycle.
- latch=0: every a12_clk reloads 0, so pending sets on every scanline while irq_en=1.
- Pending stays set until a $E000 write or reset. $E001 never clears it.
- enable=0:
  - counter, reload, latch and pending hold.
  - Writes and a12_clk are ignored.
  - irq_n=1. The A12 synchroniser keeps running.
- Outputs:
  - irq_n = ~(pending & enable).
  - irq_pending = pending.
  - Both are registered; no combinational path from inputs.
- Reset mid-frame returns to the reset state within the same cycle; any in-flight a12_clk is lost.

Optional Feature:
- Macro MMC3_REV_A_IRQ_EN selects the old (Sharp/Rev A) IRQ behaviour.
- Defined:
  - pending is set only when new==0 and (the counter was decremented from 1, or the reload flag was set).
  - A natural reload of latch=0 from counter==0 without reload does NOT set pending.
  - With latch=0, IRQ fires once after $C001 and then stops.
- Undefined: the new (Rev B/NEC) rule above applies, setting pending on any new==0.

Test Plan:
- Reset, then a12_clk edges with no writes → counter_q stays 0, irq_n=1 throughout.
- Write $C000=0x05, $C001, $E001; apply 6 filtered A12 edges → counter_q sequence 5,4,3,2,1,0; irq_n falls 1 cycle after the 6th a12_clk. Write $E000 → irq_n=1 next cycle.
- A12 high pulses with only 2 low m2 cycles between them (A12_LOW_MIN=3) → no counter change; with 3 low cycles between pulses, each pulse decrements.
- latch=0, irq_en=1, 3 edges → pending set after each edge. Under MMC3_REV_A_IRQ_EN, pending is set only after the first edge following $C001; after an ack, the 2nd and 3rd edges leave irq_n=1.
- $C001 write in the same cycle as a12_clk with counter=3 → counter_q=0, pending=0, and the next edge loads latch.
- Counter at 2, pending=1, enable dropped to 0 for 10 edges → irq_n=1, counter_q=2; enable raised → irq_n=0 again.

Source files
------------

// File: rtl/mmc3_scanline_irq_if.sv
// CPU write bus into the MMC3 scanline IRQ block.
// The writes are already decoded to the $8000-$FFFF window.
//   wr_strobe  : one-cycle pulse, a write has completed
//   wr_a14_13  : CPU A14:A13 of that write
//   wr_a0      : CPU A0 of that write
//   wr_data    : CPU data of that write
// Modports: master drives the bus (CPU decode side), slave receives it (IRQ block).
interface mmc3_scanline_irq_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 wr_strobe;
  logic [1:0]           wr_a14_13;
  logic                 wr_a0;
  logic [CNT_WIDTH-1:0] wr_data;

  modport master (output wr_strobe, output wr_a14_13, output wr_a0, output wr_data);
  modport slave  (input  wr_strobe, input  wr_a14_13, input  wr_a0, input  wr_data);
endinterface

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ generator.
// This block counts filtered PPU A12 rising edges (scanline clocks) with a reloadable
// down-counter. It raises an active-low IRQ request when the counter reaches zero
// while IRQs are enabled.
//
// Ports:
//   m2          CPU M2 clock; all state changes on its rising edge
//   reset_n     synchronous active-low reset
//   enable      block selected by current mapper; 0 freezes state, forces irq_n high
//   wr          CPU write bus (slave modport of mmc3_scanline_irq_if)
//   ppu_a12     raw PPU A12, asynchronous to m2
//   irq_n       registered IRQ request, 0 = asserted
//   irq_pending registered pending flag for status readback
//   counter_q   current counter value
//
// Build option: define MMC3_REV_A_IRQ_EN for the old (Sharp/Rev A) IRQ rule. Under
// that rule, pending is set on a zero result only when the counter decremented from 1
// or the reload flag was set. The default is the Rev B/NEC rule, where any zero
// result sets pending.
module mmc3_scanline_irq #(
  parameter int A12_LOW_MIN = 3,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  m2,
  input  logic                  reset_n,
  input  logic                  enable,
  mmc3_scanline_irq_if.slave    wr,
  input  logic                  ppu_a12,
  output logic                  irq_n,
  output logic                  irq_pending,
  output logic [CNT_WIDTH-1:0]  counter_q
);
  localparam int LW = $clog2(A12_LOW_MIN + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_MIN);

  logic                 a12_s1, a12_s2;
  logic [LW-1:0]        low_cnt;
  logic                 a12_clk;

  logic [CNT_WIDTH-1:0] latch, counter, latch_nxt, counter_nxt, new_val;
  logic                 reload, irq_en, pending;
  logic                 reload_nxt, irq_en_nxt, pending_nxt;
  logic                 wr_hit, set_pend;

  // low_cnt is cleared while synced A12 is high. A saturated count together with
  // a12_s2 high therefore marks the first high cycle after a long-enough low period.
  assign a12_clk = a12_s2 && (low_cnt == LOW_MAX);

  always_comb begin
    latch_nxt   = latch;
    counter_nxt = counter;
    reload_nxt  = reload;
    irq_en_nxt  = irq_en;
    pending_nxt = pending;
    wr_hit      = wr.wr_strobe && enable;
    new_val     = (counter == '0 || reload) ? latch : counter - 1'b1;
`ifdef MMC3_REV_A_IRQ_EN
    set_pend    = (new_val == '0) && irq_en &&
                  (reload || counter == CNT_WIDTH'(1));
`else
    set_pend    = (new_val == '0) && irq_en;
`endif
    if (enable) begin
      // A $C001 write swallows a coincident scanline clock.
      if (wr_hit && wr.wr_a14_13 == 2'd2 && wr.wr_a0) begin
        counter_nxt = '0;
        reload_nxt  = 1'b1;
      end else if (a12_clk) begin
        counter_nxt = new_val;
        reload_nxt  = 1'b0;
        if (set_pend) pending_nxt = 1'b1;
      end
      // new_val above used the old latch, so a same-cycle $C000 takes effect next cycle.
      if (wr_hit && wr.wr_a14_13 == 2'd2 && !wr.wr_a0)
        latch_nxt = wr.wr_data;
      if (wr_hit && wr.wr_a14_13 == 2'd3) begin
        irq_en_nxt = wr.wr_a0;
        if (!wr.wr_a0) pending_nxt = 1'b0;  // ack beats a same-cycle set
      end
    end
  end

  always_ff @(posedge m2) begin
    if (!reset_n) begin
      a12_s1  <= 1'b0;
      a12_s2  <= 1'b0;
      low_cnt <= '0;
      latch   <= '0;
      counter <= '0;
      reload  <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
      irq_n   <= 1'b1;
    end else begin
      a12_s1  <= ppu_a12;
      a12_s2  <= a12_s1;
      if (a12_s2)                low_cnt <= '0;
      else if (low_cnt != LOW_MAX) low_cnt <= low_cnt + 1'b1;
      latch   <= latch_nxt;
      counter <= counter_nxt;
      reload  <= reload_nxt;
      irq_en  <= irq_en_nxt;
      pending <= pending_nxt;
      irq_n   <= ~(pending_nxt & enable);
    end
  end

  assign irq_pending = pending;
  assign counter_q   = counter;
endmodule

// File: tb/tb_mmc3_scanline_irq.sv
module tb_mmc3_scanline_irq;
  localparam int LOW = 3;
  localparam int W   = 8;

  logic m2 = 1'b0, reset_n = 1'b0, enable = 1'b1, ppu_a12 = 1'b0;
  logic irq_n, irq_pending;
  logic [W-1:0] counter_q;

  mmc3_scanline_irq_if #(.CNT_WIDTH(W)) bus ();

  mmc3_scanline_irq #(.A12_LOW_MIN(LOW), .CNT_WIDTH(W)) dut (
    .m2(m2), .reset_n(reset_n), .enable(enable), .wr(bus.slave), .ppu_a12(ppu_a12),
    .irq_n(irq_n), .irq_pending(irq_pending), .counter_q(counter_q)
  );

  always #5 m2 = ~m2;

  int nvec = 0, nfail = 0;
  logic chk_on = 1'b0;

`ifdef MMC3_REV_A_IRQ_EN
  localparam logic REV_A = 1'b1;
`else
  localparam logic REV_A = 1'b0;
`endif

  // Model state. hist holds the raw A12 samples seen on past edges; hist[0] is the most recent.
  typedef struct {
    logic [W-1:0]   cnt, latch;
    logic           rel, ien, pend, irqn;
    logic [LOW+1:0] hist;
    int             hv;
  } ms_t;
  ms_t m;

  // A scanline clock lands two edges after the raw rise is sampled. It counts only if
  // the LOW samples before that rise were all low. Reset leaves two known-low samples.
  function automatic ms_t step(ms_t s, logic rst, logic en, logic stb, logic [1:0] a,
                               logic a0, logic [W-1:0] d, logic a12);
    ms_t n = s;
    logic ev, set;
    logic [W-1:0] nv;
    if (!rst) begin
      n.cnt = '0; n.latch = '0; n.rel = 0; n.ien = 0; n.pend = 0; n.irqn = 1;
      n.hist = '0; n.hv = 2;
      return n;
    end
    ev = 0;
    if (s.hv >= LOW + 2) begin
      ev = s.hist[1];
      for (int i = 2; i <= LOW + 1; i++) if (s.hist[i]) ev = 0;
    end
    n.hist = {s.hist[LOW:0], a12};
    n.hv   = (s.hv < 1000) ? s.hv + 1 : 1000;
    if (en) begin
      if (stb && a == 2 && a0) begin
        n.cnt = 0; n.rel = 1;
      end else if (ev) begin
        nv  = (s.cnt == 0 || s.rel) ? s.latch : W'(s.cnt - 1);
        set = (nv == 0) && s.ien;
        if (REV_A) set = set && (s.rel || s.cnt == 1);
        n.cnt = nv; n.rel = 0;
        if (set) n.pend = 1;
      end
      if (stb && a == 2 && !a0) n.latch = d;
      if (stb && a == 3) begin
        n.ien = a0;
        if (!a0) n.pend = 0;
      end
    end
    n.irqn = !(n.pend && en);
    return n;
  endfunction

  always @(posedge m2)
    m <= step(m, reset_n, enable, bus.wr_strobe, bus.wr_a14_13, bus.wr_a0, bus.wr_data, ppu_a12);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge m2) if (chk_on) begin
    chk("model_cnt",  32'(counter_q),   32'(m.cnt));
    chk("model_pend", 32'(irq_pending), 32'(m.pend));
    chk("model_irqn", 32'(irq_n),       32'(m.irqn));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge m2);
  endtask

  task automatic wr(input logic [1:0] a, input logic a0, input logic [W-1:0] d);
    bus.wr_strobe = 1; bus.wr_a14_13 = a; bus.wr_a0 = a0; bus.wr_data = d;
    tick(1);
    bus.wr_strobe = 0;
  endtask

  task automatic pulse(input int hi, input int lo);
    ppu_a12 = 1; tick(hi);
    ppu_a12 = 0; tick(lo);
  endtask

  // One filtered scanline edge; the counter has settled by the time this returns.
  task automatic edge1();
    pulse(2, 6);
  endtask

  initial begin
    bus.wr_strobe = 0; bus.wr_a14_13 = 0; bus.wr_a0 = 0; bus.wr_data = 0;
    tick(1);
    chk_on = 1;
    tick(2);
    chk("rst_cnt",  32'(counter_q),   0);
    chk("rst_irqn", 32'(irq_n),       1);
    chk("rst_pend", 32'(irq_pending), 0);
    reset_n = 1;
    tick(4);

    // Edges with nothing written: latch 0, IRQs disabled.
    repeat (3) edge1();
    chk("noprog_cnt",  32'(counter_q), 0);
    chk("noprog_irqn", 32'(irq_n),     1);

    // Basic countdown 5..0.
    wr(2, 0, 8'h05); wr(2, 1, 0); wr(3, 1, 0);
    for (int i = 0; i < 6; i++) begin
      edge1();
      chk("seq_cnt", 32'(counter_q), 32'(5 - i));
      chk("seq_irqn", 32'(irq_n), (i < 5) ? 1 : 0);
    end
    wr(3, 0, 0);
    chk("ack_irqn", 32'(irq_n),       1);
    chk("ack_pend", 32'(irq_pending), 0);

    // A12 low-time filter.
    wr(2, 0, 8'h10); wr(2, 1, 0);
    edge1();
    chk("filt_load", 32'(counter_q), 16);
    repeat (3) pulse(2, 2);
    tick(4);
    chk("filt_short", 32'(counter_q), 15);
    repeat (3) pulse(2, 3);
    tick(4);
    chk("filt_ok", 32'(counter_q), 12);

    // latch = 0: Rev B fires every scanline, Rev A only after $C001.
    wr(2, 0, 0); wr(2, 1, 0); wr(3, 1, 0);
    edge1();
    chk("l0_first", 32'(irq_pending), 1);
    for (int i = 0; i < 2; i++) begin
      wr(3, 0, 0); wr(3, 1, 0);
      edge1();
      chk("l0_next_pend", 32'(irq_pending), REV_A ? 0 : 1);
      chk("l0_next_irqn", 32'(irq_n),       REV_A ? 1 : 0);
    end

    // $E000 in the same cycle as a pending-setting edge: the clear wins.
    wr(3, 0, 0); wr(3, 1, 0);
    ppu_a12 = 1; tick(2); wr(3, 0, 0); ppu_a12 = 0; tick(6);
    chk("e000_coinc", 32'(irq_pending), 0);

    // $C001 in the same cycle as an edge with counter 3.
    wr(2, 0, 8'h03); wr(2, 1, 0); wr(3, 1, 0);
    edge1();
    chk("c001_pre", 32'(counter_q), 3);
    ppu_a12 = 1; tick(2); wr(2, 1, 0); ppu_a12 = 0; tick(6);
    chk("c001_cnt",  32'(counter_q),   0);
    chk("c001_pend", 32'(irq_pending), 0);
    edge1();
    chk("c001_next", 32'(counter_q), 3);

    // enable low freezes state and masks irq_n.
    wr(2, 0, 8'h01); wr(2, 1, 0);
    edge1(); edge1();
    chk("en_pend0", 32'(irq_pending), 1);
    wr(2, 0, 8'h03);
    edge1(); edge1();
    chk("en_cnt2", 32'(counter_q), 2);
    chk("en_irq0", 32'(irq_n),     0);
    enable = 0;
    repeat (10) edge1();
    chk("dis_irqn", 32'(irq_n),       1);
    chk("dis_cnt",  32'(counter_q),   2);
    chk("dis_pend", 32'(irq_pending), 1);
    enable = 1;
    tick(1);
    chk("reen_irqn", 32'(irq_n), 0);

    // Reset on the cycle an edge would land: state cleared, the edge lost.
    ppu_a12 = 1; tick(2);
    reset_n = 0; tick(1); reset_n = 1; ppu_a12 = 0;
    chk("mid_rst_cnt",  32'(counter_q),   0);
    chk("mid_rst_irqn", 32'(irq_n),       1);
    chk("mid_rst_pend", 32'(irq_pending), 0);
    tick(6);
    chk("mid_rst_after", 32'(counter_q), 0);

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
